// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - shared memory bus arbiter between the CPU MEM stage and a DMA/loader port
// Round-robin between the two requesters, with fixed MEM_LAT-cycle accesses.
module data_bus_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_cpu;
    logic       last_cyc;

    assign last_cyc = (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_cpu  <= 1'b0;
            dma_ack   <= 1'b0;
            dma_rdata <= 32'd0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    // On a tie, the requester not served most recently wins.
                    if (cpu_req && (!dma_req || !last_cpu))
                        state <= CPU_ACC;
                    else if (dma_req)
                        state <= DMA_ACC;
                end
                CPU_ACC: begin
                    if (last_cyc) begin
                        cnt      <= 4'd0;
                        last_cpu <= 1'b1;
                        state    <= dma_req ? DMA_ACC : IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DMA_ACC: begin
                    if (last_cyc) begin
                        cnt      <= 4'd0;
                        last_cpu <= 1'b0;
                        dma_ack  <= 1'b1;
                        if (!dma_wr)
                            dma_rdata <= bus_rdata;
                        state <= cpu_req ? CPU_ACC : IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Bus side is a pure mux of the granted requester, so an async reset
    // drops the strobes as soon as the state register clears.
    always_comb begin
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        cpu_rdata = 32'd0;
        case (state)
            CPU_ACC: begin
                bus_rd    = ~cpu_wr;
                bus_wr    = cpu_wr;
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                cpu_rdata = bus_rdata;
            end
            DMA_ACC: begin
                bus_rd    = ~dma_wr;
                bus_wr    = dma_wr;
                bus_addr  = dma_addr;
                bus_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req && !((state == CPU_ACC) && last_cyc);

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

    localparam int LAT = 2;

    logic        clk, reset;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, bus_rdata;
    logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
    logic        cpu_stall, dma_ack, bus_rd, bus_wr;
    logic [31:0] o1_cpu_rdata, o1_dma_rdata, o1_bus_addr, o1_bus_wdata;
    logic        o1_cpu_stall, o1_dma_ack, o1_bus_rd, o1_bus_wr;

    int n_chk = 0;
    int n_fail = 0;

    data_bus_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    data_bus_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(o1_cpu_rdata), .cpu_stall(o1_cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(o1_dma_rdata), .dma_ack(o1_dma_ack),
        .bus_rd(o1_bus_rd), .bus_wr(o1_bus_wr), .bus_addr(o1_bus_addr), .bus_wdata(o1_bus_wdata),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic erd, input logic ewr,
                            input logic [31:0] eaddr, input logic [31:0] ewdata,
                            input logic est, input logic [31:0] ecrd,
                            input logic eack, input logic [31:0] edrd);
        chk({tag, ".bus_rd"},    32'(bus_rd),    32'(erd));
        chk({tag, ".bus_wr"},    32'(bus_wr),    32'(ewr));
        chk({tag, ".bus_addr"},  bus_addr,       eaddr);
        chk({tag, ".bus_wdata"}, bus_wdata,      ewdata);
        chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(est));
        chk({tag, ".cpu_rdata"}, cpu_rdata,      ecrd);
        chk({tag, ".dma_ack"},   32'(dma_ack),   32'(eack));
        chk({tag, ".dma_rdata"}, dma_rdata,      edrd);
    endtask

    typedef struct {
        logic        creq, cwr, dreq, dwr;
        logic [31:0] rdata;
        logic        rd, wr, stall;
        logic [31:0] crd;
        logic        ack;
        logic [31:0] drd, addr, wdata;
    } vec_t;

    function automatic vec_t mk(input logic creq, input logic cwr, input logic dreq, input logic dwr,
                                input logic [31:0] rdata, input logic rd, input logic wr,
                                input logic stall, input logic [31:0] crd, input logic ack,
                                input logic [31:0] drd, input logic [31:0] addr,
                                input logic [31:0] wdata);
        vec_t v;
        v.creq = creq; v.cwr = cwr; v.dreq = dreq; v.dwr = dwr; v.rdata = rdata;
        v.rd = rd; v.wr = wr; v.stall = stall; v.crd = crd; v.ack = ack;
        v.drd = drd; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    vec_t tbl [15];

    // Transaction-level reference: who owns the bus and how far into the access it is.
    int          m_who;
    int          m_cnt;
    logic        m_lastcpu, m_ack;
    logic [31:0] m_rdata;
    logic        cpu_pend, dma_pend, dma_drop;

    initial begin
        // CPU read alone, DMA write alone, then simultaneous first requests
        tbl[0]  = mk(1,0,0,0,32'h1234, 0,0,1,32'h0,   0,32'h0,   32'h0, 32'h0);
        tbl[1]  = mk(1,0,0,0,32'h1234, 1,0,1,32'h1234,0,32'h0,   32'h40,32'h1111);
        tbl[2]  = mk(1,0,0,0,32'h1234, 1,0,0,32'h1234,0,32'h0,   32'h40,32'h1111);
        tbl[3]  = mk(0,0,0,0,32'h1234, 0,0,0,32'h0,   0,32'h0,   32'h0, 32'h0);
        tbl[4]  = mk(0,0,1,1,32'h5555, 0,0,0,32'h0,   0,32'h0,   32'h0, 32'h0);
        tbl[5]  = mk(0,0,1,1,32'h5555, 0,1,0,32'h0,   0,32'h0,   32'h80,32'hABCD);
        tbl[6]  = mk(0,0,1,1,32'h5555, 0,1,0,32'h0,   0,32'h0,   32'h80,32'hABCD);
        tbl[7]  = mk(0,0,0,0,32'h5555, 0,0,0,32'h0,   1,32'h0,   32'h0, 32'h0);
        tbl[8]  = mk(0,0,0,0,32'h5555, 0,0,0,32'h0,   0,32'h0,   32'h0, 32'h0);
        tbl[9]  = mk(1,0,1,0,32'h7777, 0,0,1,32'h0,   0,32'h0,   32'h0, 32'h0);
        tbl[10] = mk(1,0,1,0,32'h7777, 1,0,1,32'h7777,0,32'h0,   32'h40,32'h1111);
        tbl[11] = mk(1,0,1,0,32'h7777, 1,0,0,32'h7777,0,32'h0,   32'h40,32'h1111);
        tbl[12] = mk(0,0,1,0,32'h7777, 1,0,0,32'h0,   0,32'h0,   32'h80,32'hABCD);
        tbl[13] = mk(0,0,1,0,32'h7777, 1,0,0,32'h0,   0,32'h0,   32'h80,32'hABCD);
        tbl[14] = mk(0,0,0,0,32'h7777, 0,0,0,32'h0,   1,32'h7777,32'h0, 32'h0);

        reset = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0; dma_req = 1'b0; dma_wr = 1'b0;
        cpu_addr = 32'h40; cpu_wdata = 32'h1111; dma_addr = 32'h80; dma_wdata = 32'hABCD;
        bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_main("reset", 0, 0, 32'h0, 32'h0, 1, 32'h0, 0, 32'h0);
        cpu_req = 1'b0;
        #1 chk("reset.stall_follows", 32'(cpu_stall), 32'h0);
        reset = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            cpu_req = tbl[i].creq; cpu_wr = tbl[i].cwr;
            dma_req = tbl[i].dreq; dma_wr = tbl[i].dwr;
            bus_rdata = tbl[i].rdata;
            #1 chk_main($sformatf("tbl[%0d]", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                        tbl[i].stall, tbl[i].crd, tbl[i].ack, tbl[i].drd);
        end

        // Sustained contention: DMA was served last, so CPU wins first, then strict alternation.
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; dma_req = 1'b1; dma_wr = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("contend[%0d].owner", k), bus_addr, (((k - 1) / LAT) % 2 == 0) ? 32'h40 : 32'h80);
            chk($sformatf("contend[%0d].bus_rd", k), 32'(bus_rd), 32'h1);
        end
        @(negedge clk);
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the first cycle of a DMA read.
        dma_req = 1'b1; dma_wr = 1'b0; bus_rdata = 32'hDEAD;
        @(negedge clk);
        #1 chk("rstmid.pre_bus_rd", 32'(bus_rd), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rstmid.bus_rd", 32'(bus_rd), 32'h0);
        chk("rstmid.bus_addr", bus_addr, 32'h0);
        dma_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstmid[%0d].dma_ack", k), 32'(dma_ack), 32'h0);
            chk($sformatf("rstmid[%0d].dma_rdata", k), dma_rdata, 32'h0);
        end

        // MEM_LAT=1 instance: single-cycle CPU read, then one-cycle alternation.
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; bus_rdata = 32'h4321;
        #1;
        chk("lat1.c0.stall", 32'(o1_cpu_stall), 32'h1);
        chk("lat1.c0.bus_rd", 32'(o1_bus_rd), 32'h0);
        @(negedge clk);
        #1;
        chk("lat1.c1.bus_rd", 32'(o1_bus_rd), 32'h1);
        chk("lat1.c1.stall", 32'(o1_cpu_stall), 32'h0);
        chk("lat1.c1.cpu_rdata", o1_cpu_rdata, 32'h4321);
        @(negedge clk);
        cpu_req = 1'b0;
        #1 chk("lat1.c2.bus_rd", 32'(o1_bus_rd), 32'h0);
        @(negedge clk);
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat1.alt[%0d]", k), o1_bus_addr, (k % 2 == 0) ? 32'h80 : 32'h40);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the reference model.
        m_who = 0; m_cnt = 0; m_lastcpu = 1'b0; m_ack = 1'b0; m_rdata = 32'h0;
        cpu_pend = 1'b0; dma_pend = 1'b0; dma_drop = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic last, erd, ewr;
            logic [31:0] eaddr, ewd;
            @(negedge clk);
            if (!cpu_pend && $urandom_range(0, 2) == 0) begin
                cpu_pend = 1'b1;
                cpu_wr = 1'($urandom_range(0, 1));
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (!dma_pend && $urandom_range(0, 2) == 0) begin
                dma_pend = 1'b1;
                dma_wr = 1'($urandom_range(0, 1));
                dma_addr = $urandom; dma_wdata = $urandom;
            end else if (dma_pend && m_who == 2 && $urandom_range(0, 3) == 0) begin
                dma_drop = 1'b1;
            end
            cpu_req = cpu_pend;
            dma_req = dma_pend && !dma_drop;
            bus_rdata = $urandom;
            #1;
            last  = (m_who != 0) && (m_cnt == LAT - 1);
            erd   = (m_who == 1) ? !cpu_wr : (m_who == 2) ? !dma_wr : 1'b0;
            ewr   = (m_who == 1) ? cpu_wr  : (m_who == 2) ? dma_wr  : 1'b0;
            eaddr = (m_who == 1) ? cpu_addr : (m_who == 2) ? dma_addr : 32'h0;
            ewd   = (m_who == 1) ? cpu_wdata : (m_who == 2) ? dma_wdata : 32'h0;
            chk_main($sformatf("rand[%0d]", c), erd, ewr, eaddr, ewd,
                     cpu_req && !(m_who == 1 && last),
                     (m_who == 1) ? bus_rdata : 32'h0, m_ack, m_rdata);
            @(posedge clk);
            m_ack = 1'b0;
            if (m_who == 0) begin
                if (cpu_req && dma_req) m_who = m_lastcpu ? 2 : 1;
                else if (cpu_req)       m_who = 1;
                else if (dma_req)       m_who = 2;
                m_cnt = 0;
            end else if (last) begin
                if (m_who == 1) begin
                    m_lastcpu = 1'b1;
                    cpu_pend = 1'b0;
                    m_who = dma_req ? 2 : 0;
                end else begin
                    m_lastcpu = 1'b0;
                    m_ack = 1'b1;
                    if (!dma_wr) m_rdata = bus_rdata;
                    dma_pend = 1'b0;
                    dma_drop = 1'b0;
                    m_who = cpu_req ? 1 : 0;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
